note_lookup_arbiter: RTL and testbench

NOTE_LOOKUP_ARBITER -- requirements
Module: note_lookup_arbiter

---
 rtl/note_lookup_arbiter.sv | 143 ++++++++++++++
 tb/tb_note_lookup_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_lookup_arbiter.sv
// Round-robin arbiter that time-shares one note_table among three channels.
// Optional `NOTE_ARB_MUTE_EN adds i_mute to zero individual phase-delta outputs.
module note_lookup_arbiter #(
   parameter int LUT_WAIT = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
`ifdef NOTE_ARB_MUTE_EN
   input  logic [2:0]  i_mute,
`endif
   input  logic [2:0]  i_req,
   input  logic [5:0]  i_note0,
   input  logic [5:0]  i_note1,
   input  logic [5:0]  i_note2,
   output logic [2:0]  o_ack,
   output logic [5:0]  o_lut_note,
   input  logic [31:0] i_lut_compare,
   output logic [31:0] o_phase_delta0,
   output logic [31:0] o_phase_delta1,
   output logic [31:0] o_phase_delta2,
   output logic        o_busy
);

   typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_t;

   localparam logic [1:0] WAIT_LAST = 2'(LUT_WAIT - 1);

   state_t      state, state_nxt;
   logic [1:0]  last_grant;
   logic [1:0]  winner;
   logic [1:0]  grant_sel;
   logic        grant_any;
   logic [5:0]  grant_note;
   logic [5:0]  note_lat;
   logic [1:0]  wait_cnt;
   logic        lut_last;
   logic [31:0] delta0_q, delta1_q, delta2_q;

   assign lut_last = (wait_cnt == WAIT_LAST);

   // Search order starts one past the previous winner so nobody waits behind more than two lookups.
   always_comb begin
      grant_any = |i_req;
      grant_sel = 2'd0;
      case (last_grant)
         2'd0: begin
            if (i_req[1])      grant_sel = 2'd1;
            else if (i_req[2]) grant_sel = 2'd2;
            else               grant_sel = 2'd0;
         end
         2'd1: begin
            if (i_req[2])      grant_sel = 2'd2;
            else if (i_req[0]) grant_sel = 2'd0;
            else               grant_sel = 2'd1;
         end
         default: begin
            if (i_req[0])      grant_sel = 2'd0;
            else if (i_req[1]) grant_sel = 2'd1;
            else               grant_sel = 2'd2;
         end
      endcase
   end

   always_comb begin
      case (grant_sel)
         2'd0:    grant_note = i_note0;
         2'd1:    grant_note = i_note1;
         default: grant_note = i_note2;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = LOOKUP;
         LOOKUP:  if (lut_last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The note is frozen at grant time so requesters may change i_noteN mid-lookup.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_grant <= 2'd2;
         winner     <= 2'd0;
         note_lat   <= 6'd0;
         wait_cnt   <= 2'd0;
         delta0_q   <= 32'd0;
         delta1_q   <= 32'd0;
         delta2_q   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  winner   <= grant_sel;
                  note_lat <= grant_note;
                  wait_cnt <= 2'd0;
               end
            end
            LOOKUP: begin
               wait_cnt <= wait_cnt + 2'd1;
               if (lut_last) begin
                  case (winner)
                     2'd0:    delta0_q <= i_lut_compare;
                     2'd1:    delta1_q <= i_lut_compare;
                     default: delta2_q <= i_lut_compare;
                  endcase
               end
            end
            DONE:    last_grant <= winner;
            default: ;
         endcase
      end
   end

   always_comb begin
      o_ack      = 3'b000;
      o_lut_note = 6'd0;
      o_busy     = (state != IDLE);
      case (state)
         LOOKUP:  o_lut_note = note_lat;
         DONE:    o_ack = 3'(3'b001 << winner);
         default: ;
      endcase
   end

`ifdef NOTE_ARB_MUTE_EN
   assign o_phase_delta0 = i_mute[0] ? 32'd0 : delta0_q;
   assign o_phase_delta1 = i_mute[1] ? 32'd0 : delta1_q;
   assign o_phase_delta2 = i_mute[2] ? 32'd0 : delta2_q;
`else
   assign o_phase_delta0 = delta0_q;
   assign o_phase_delta1 = delta1_q;
   assign o_phase_delta2 = delta2_q;
`endif

endmodule

// File: tb/tb_note_lookup_arbiter.sv
// Scoreboard bench for note_lookup_arbiter: one DUT at LUT_WAIT=1, one at LUT_WAIT=3.
// The mute scenario only runs when NOTE_ARB_MUTE_EN is defined.
module tb_note_lookup_arbiter;

   typedef struct {
      logic [1:0]  chan;
      logic [31:0] delta;
      int          gap;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [5:0]  note0, note1, note2;
   logic [2:0]  ack;
   logic [5:0]  lut_note;
   logic [31:0] lut_compare;
   logic [31:0] delta0, delta1, delta2;
   logic        busy;
   logic [2:0]  mute;

   logic [2:0]  req3;
   logic [5:0]  n3;
   logic [2:0]  ack3;
   logic [5:0]  lut_note3;
   logic [31:0] lut_compare3;
   logic [31:0] delta3_0, delta3_1, delta3_2;
   logic        busy3;
   logic [1:0]  cnt3;

   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   int          last_ack_cyc = 0;
   exp_t        score_q[$];
   logic [31:0] exp_delta [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   note_lookup_arbiter #(.LUT_WAIT(1)) dut (
      .i_clk(clk), .i_rst(rst),
`ifdef NOTE_ARB_MUTE_EN
      .i_mute(mute),
`endif
      .i_req(req), .i_note0(note0), .i_note1(note1), .i_note2(note2),
      .o_ack(ack), .o_lut_note(lut_note), .i_lut_compare(lut_compare),
      .o_phase_delta0(delta0), .o_phase_delta1(delta1), .o_phase_delta2(delta2),
      .o_busy(busy)
   );

   note_lookup_arbiter #(.LUT_WAIT(3)) dut3 (
      .i_clk(clk), .i_rst(rst),
`ifdef NOTE_ARB_MUTE_EN
      .i_mute(3'b000),
`endif
      .i_req(req3), .i_note0(n3), .i_note1(n3), .i_note2(n3),
      .o_ack(ack3), .o_lut_note(lut_note3), .i_lut_compare(lut_compare3),
      .o_phase_delta0(delta3_0), .o_phase_delta1(delta3_1), .o_phase_delta2(delta3_2),
      .o_busy(busy3)
   );

   function automatic logic [31:0] lutFn(input logic [5:0] n);
      if (n == 6'd5)       return 32'h0000_1234;
      else if (n == 6'd10) return 32'h0000_ABCD;
      else                 return ({26'd0, n} * 32'h0101_0101) + 32'h10;
   endfunction

   always_comb lut_compare = lutFn(lut_note);

   // The slow table only presents a real result during the third LOOKUP cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) cnt3 <= 2'd0;
      else     cnt3 <= (lut_note3 != 6'd0) ? cnt3 + 2'd1 : 2'd0;
   end
   always_comb lut_compare3 = (cnt3 == 2'd2) ? lutFn(lut_note3) : 32'hDEAD_BEEF;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] r, input logic [5:0] n0, input logic [5:0] n1, input logic [5:0] n2);
      @(negedge clk);
      req   = r;
      note0 = n0;
      note1 = n1;
      note2 = n2;
   endtask

   task automatic pushExp(input logic [1:0] chan, input logic [31:0] delta, input int gap);
      exp_t e;
      e.chan  = chan;
      e.delta = delta;
      e.gap   = gap;
      score_q.push_back(e);
   endtask

   task automatic waitAcks(input int n, input int budget);
      int seen = 0;
      for (int i = 0; i < budget && seen < n; i++) begin
         @(negedge clk);
         if (ack != 3'b000) seen++;
      end
      if (seen < n) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL ack_timeout: got %0d acks expected %0d", seen, n);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) exp_delta[i] = 32'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every ack pops the next expected grant and checks all three delta registers.
   always @(negedge clk) begin
      if (!rst && ack != 3'b000) begin
         if (score_q.size() == 0) begin
            checkOutput("unexpected_ack", {29'd0, ack}, 32'd0);
         end else begin
            exp_t e;
            e = score_q.pop_front();
            exp_delta[e.chan] = e.delta;
            checkOutput("sb_ack", {29'd0, ack}, {29'd0, 3'(3'b001 << e.chan)});
            checkOutput("sb_delta0", delta0, exp_delta[0]);
            checkOutput("sb_delta1", delta1, exp_delta[1]);
            checkOutput("sb_delta2", delta2, exp_delta[2]);
            if (e.gap != 0) checkOutput("sb_ack_gap", 32'(cyc - last_ack_cyc), 32'(e.gap));
         end
         last_ack_cyc = cyc;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; req = 3'b000; note0 = 6'd0; note1 = 6'd0; note2 = 6'd0;
      req3 = 3'b000; n3 = 6'd0; mute = 3'b000;
      for (int i = 0; i < 3; i++) exp_delta[i] = 32'd0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_ack", {29'd0, ack}, 32'd0);
      checkOutput("rst_lut_note", {26'd0, lut_note}, 32'd0);
      checkOutput("rst_delta0", delta0, 32'd0);
      checkOutput("rst_delta2", delta2, 32'd0);
      rst = 1'b0;

      // Single request on channel 0
      applyStimulus(3'b001, 6'd5, 6'd0, 6'd0);
      pushExp(2'd0, 32'h0000_1234, 0);
      @(negedge clk);
      checkOutput("single_lut_note", {26'd0, lut_note}, 32'd5);
      checkOutput("single_busy", {31'd0, busy}, 32'd1);
      checkOutput("single_ack_early", {29'd0, ack}, 32'd0);
      @(negedge clk);
      checkOutput("single_ack", {29'd0, ack}, 32'd1);
      checkOutput("single_delta0", delta0, 32'h0000_1234);
      req = 3'b000;
      @(negedge clk);
      checkOutput("idle_lut_note", {26'd0, lut_note}, 32'd0);
      checkOutput("idle_busy", {31'd0, busy}, 32'd0);

      // Note changes mid-lookup must not reach the table
      applyStimulus(3'b010, 6'd0, 6'd7, 6'd0);
      pushExp(2'd1, 32'h0707_0717, 0);
      @(negedge clk);
      checkOutput("held_lut_note", {26'd0, lut_note}, 32'd7);
      note1 = 6'd9;
      @(negedge clk);
      checkOutput("done_lut_note", {26'd0, lut_note}, 32'd0);
      checkOutput("held_ack", {29'd0, ack}, 32'd2);
      req = 3'b000;

      // Winner drops its request during LOOKUP
      applyStimulus(3'b100, 6'd0, 6'd0, 6'd2);
      pushExp(2'd2, 32'h0202_0212, 0);
      @(negedge clk);
      req = 3'b000;
      waitAcks(1, 10);

      // Full contention after reset: 0,1,2,0 one ack every 3 cycles
      doReset();
      applyStimulus(3'b111, 6'd3, 6'd4, 6'd6);
      pushExp(2'd0, 32'h0303_0313, 0);
      pushExp(2'd1, 32'h0404_0414, 3);
      pushExp(2'd2, 32'h0606_0616, 3);
      pushExp(2'd0, 32'h0303_0313, 3);
      waitAcks(4, 30);
      req = 3'b000;
      @(negedge clk);

      // Reset in the middle of a lookup
      applyStimulus(3'b001, 6'd5, 6'd0, 6'd0);
      @(negedge clk);
      checkOutput("abort_busy_pre", {31'd0, busy}, 32'd1);
      #2;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) exp_delta[i] = 32'd0;
      #1;
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_lut_note", {26'd0, lut_note}, 32'd0);
      checkOutput("abort_delta0", delta0, 32'd0);
      checkOutput("abort_delta1", delta1, 32'd0);
      checkOutput("abort_delta2", delta2, 32'd0);
      req = 3'b000;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_idle", {31'd0, busy}, 32'd0);
      checkOutput("abort_no_ack", {29'd0, ack}, 32'd0);
      applyStimulus(3'b010, 6'd0, 6'd9, 6'd0);
      pushExp(2'd1, 32'h0909_0919, 0);
      waitAcks(1, 10);
      req = 3'b000;

      // LUT_WAIT=3 instance: capture on the third LOOKUP cycle, ack 4 cycles after grant
      @(negedge clk);
      req3 = 3'b001;
      n3   = 6'd8;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("w3_no_ack", {29'd0, ack3}, 32'd0);
         checkOutput("w3_busy", {31'd0, busy3}, 32'd1);
      end
      @(negedge clk);
      checkOutput("w3_ack", {29'd0, ack3}, 32'd1);
      checkOutput("w3_delta0", delta3_0, 32'h0808_0818);
      req3 = 3'b000;

`ifdef NOTE_ARB_MUTE_EN
      applyStimulus(3'b100, 6'd0, 6'd0, 6'd10);
      pushExp(2'd2, 32'h0000_ABCD, 0);
      waitAcks(1, 10);
      req = 3'b000;
      @(negedge clk);
      mute = 3'b100;
      #1;
      checkOutput("mute_on", delta2, 32'd0);
      mute = 3'b000;
      #1;
      checkOutput("mute_off", delta2, 32'h0000_ABCD);
`endif

      repeat (3) @(negedge clk);
      checkOutput("pending_acks", 32'(score_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
